// File: rtl/b_pingpong_sched_pkg.sv
// Shared types for the B-side ping-pong scheduler and its beat counter.
package b_pingpong_sched_pkg;

  localparam int unsigned CFG_W  = 16;
  localparam int unsigned N2_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef logic bank_t;

  typedef struct packed {
    logic [CFG_W-1:0] m2;
    logic [CFG_W-1:0] bw_dn2;
    logic [CFG_W-1:0] block_num;
  } cfg_t;

  // A job is only meaningful when every dimension is non-zero.
  function automatic logic cfg_ok(input cfg_t c);
    return (c.m2 != '0) && (c.bw_dn2 != '0) && (c.block_num != '0);
  endfunction

endpackage

// File: rtl/b_pingpong_sched_beat.sv
// Nested col/phase/row beat counter in writer order; flags the final beat of a block.
module b_beat_counter
  import b_pingpong_sched_pkg::*;
#(
  parameter int unsigned N2 = N2_DEF,
  parameter int unsigned W  = CFG_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] m2,
  input  logic [W-1:0] bw_dn2,
  output logic         last_beat
);

  localparam int unsigned COL_W = (N2 > 1) ? $clog2(N2) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(N2 - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [W-1:0]     phase_q, phase_d;
  logic [W-1:0]     row_q, row_d;
  logic             col_last, phase_last, row_last;

  assign col_last   = (col_q == COL_LAST);
  assign phase_last = (phase_q == (bw_dn2 - W'(1)));
  assign row_last   = (row_q == (m2 - W'(1)));
  assign last_beat  = col_last && phase_last && row_last;

  // Advance col fastest, then phase, then row; all wrap together on the last beat.
  always_comb begin
    col_d   = col_q;
    phase_d = phase_q;
    row_d   = row_q;
    if (clr) begin
      col_d   = '0;
      phase_d = '0;
      row_d   = '0;
    end else if (inc) begin
      if (col_last) begin
        col_d = '0;
        if (phase_last) begin
          phase_d = '0;
          row_d   = row_last ? '0 : row_q + W'(1);
        end else begin
          phase_d = phase_q + W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      phase_q <= '0;
      row_q   <= '0;
    end else begin
      col_q   <= col_d;
      phase_q <= phase_d;
      row_q   <= row_d;
    end
  end

endmodule

// File: rtl/b_pingpong_sched.sv
// Double-buffered B write scheduler: fills one half while compute drains the other.
module b_pingpong_sched
  import b_pingpong_sched_pkg::*;
#(
  parameter int unsigned N2           = N2_DEF,
  parameter int unsigned MATRIXSIZE_W = CFG_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MATRIXSIZE_W-1:0] M2,
  input  logic [MATRIXSIZE_W-1:0] BLOCK_WIDTHdN2,
  input  logic [MATRIXSIZE_W-1:0] BLOCK_NUM,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    valid_B,
  output logic                    wr_bank,
  output logic                    writer_rst,
  output logic                    compute_start,
  output logic                    rd_bank,
  input  logic                    compute_done,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err
);

  state_e           state_q, state_d;
  cfg_t             cfg_in, cfg_q, cfg_d;
  logic [CFG_W-1:0] loaded_q, loaded_d;
  logic [CFG_W-1:0] bdone_q, bdone_d;
  logic [1:0]       full_q, full_d;
  logic             cbusy_q, cbusy_d;
  bank_t            wr_bank_q, wr_bank_d;
  bank_t            rd_bank_q, rd_bank_d;
  logic             cs_q, cs_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             wrst_q, wrst_d;
  logic             busy_q, busy_d;

  logic             run, accept_job, last_beat, launch, rel, last_rel;

  assign cfg_in = '{m2: CFG_W'(M2), bw_dn2: CFG_W'(BLOCK_WIDTHdN2), block_num: CFG_W'(BLOCK_NUM)};

  assign run        = (state_q == RUN);
  assign accept_job = (state_q == IDLE) && start && cfg_ok(cfg_in);
  assign in_ready   = run && !full_q[wr_bank_q] && (loaded_q < cfg_q.block_num);
  assign valid_B    = in_valid && in_ready;
  assign launch     = run && !cbusy_q && full_q[rd_bank_q] && !cs_q;
  assign rel        = run && compute_done && cbusy_q;
  assign last_rel   = rel && (bdone_q == (cfg_q.block_num - CFG_W'(1)));

  b_beat_counter #(
    .N2 (N2),
    .W  (CFG_W)
  ) u_beat (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept_job),
    .inc       (valid_B),
    .m2        (cfg_q.m2),
    .bw_dn2    (cfg_q.bw_dn2),
    .last_beat (last_beat)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: enter RUN on an accepted start, leave after the final release.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_job) state_d = RUN;
      RUN:     if (last_rel)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bank flags, block counters and registered handshake outputs.
  always_comb begin
    cfg_d     = cfg_q;
    loaded_d  = loaded_q;
    bdone_d   = bdone_q;
    full_d    = full_q;
    cbusy_d   = cbusy_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wrst_d    = wrst_q;
    busy_d    = busy_q;
    cs_d      = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (state_q == IDLE) begin
      if (start && !cfg_ok(cfg_in)) begin
        err_d = 1'b1;
      end else if (accept_job) begin
        cfg_d     = cfg_in;
        loaded_d  = '0;
        bdone_d   = '0;
        full_d    = '0;
        cbusy_d   = 1'b0;
        wr_bank_d = 1'b0;
        rd_bank_d = 1'b0;
        busy_d    = 1'b1;
        wrst_d    = 1'b0;
      end
    end else begin
      // Fill and release always target different halves, so both may land together.
      if (valid_B && last_beat) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        loaded_d          = loaded_q + CFG_W'(1);
      end
      if (launch) begin
        cs_d    = 1'b1;
        cbusy_d = 1'b1;
      end
      if (rel) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        cbusy_d           = 1'b0;
        bdone_d           = bdone_q + CFG_W'(1);
      end
      if (last_rel) begin
        done_d = 1'b1;
        busy_d = 1'b0;
        wrst_d = 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q     <= '0;
      loaded_q  <= '0;
      bdone_q   <= '0;
      full_q    <= '0;
      cbusy_q   <= 1'b0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      cs_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wrst_q    <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      loaded_q  <= loaded_d;
      bdone_q   <= bdone_d;
      full_q    <= full_d;
      cbusy_q   <= cbusy_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      cs_q      <= cs_d;
      done_q    <= done_d;
      err_q     <= err_d;
      wrst_q    <= wrst_d;
      busy_q    <= busy_d;
    end
  end

  assign wr_bank       = wr_bank_q;
  assign rd_bank       = rd_bank_q;
  assign writer_rst    = wrst_q;
  assign compute_start = cs_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cfg_err       = err_q;

endmodule

// File: doc/b_pingpong_sched.md
Name: b_pingpong_sched

Overview:
- Scheduler for the double-buffered B-matrix write path. Accepts a streamed B-block source with a valid/ready handshake and drives the B write-address generator (valid_B, writer reset) into one of two buffer halves.
- Hands filled halves to the compute engine with start/done handshakes.
- Overlaps loading of block k+1 with compute on block k, for BLOCK_NUM blocks per job.

Parameters:
N2, 4, number of B column banks; beats per row-phase.
MATRIXSIZE_W, 16, width of dimension/config inputs and counters.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  job start pulse; sampled only in IDLE
M2  in  MATRIXSIZE_W  rows per B block
BLOCK_WIDTHdN2  in  MATRIXSIZE_W  block width divided by N2
BLOCK_NUM  in  MATRIXSIZE_W  blocks per job
in_valid  in  1  upstream B data valid
in_ready  out  1  upstream may transfer (combinational)
valid_B  out  1  write strobe to B writer; equals in_valid && in_ready
wr_bank  out  1  buffer half currently being written
writer_rst  out  1  reset to B write-address generator
compute_start  out  1  one-cycle pulse: half rd_bank is full and ready
rd_bank  out  1  buffer half owned by compute
compute_done  in  1  compute finished with rd_bank
busy  out  1  job in progress
done  out  1  one-cycle pulse after last block computed
cfg_err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset values:
  - state IDLE.
  - in_ready=0, valid_B=0, wr_bank=0, rd_bank=0, writer_rst=1, compute_start=0, busy=0, done=0, cfg_err=0.
  - full[1:0]=0, all counters 0.
- Reset mid-operation: abandons the job and returns to the reset values. No done pulse.
- FSM states: IDLE, RUN.
- IDLE, start=1:
  - Any of M2, BLOCK_WIDTHdN2, BLOCK_NUM equal to 0: cfg_err pulses next cycle; stay IDLE.
  - Otherwise: latch config, clear counters/flags, go to RUN. Next cycle busy=1 and writer_rst=0.
- writer_rst is registered: 1 in IDLE, 0 in RUN.
- Write side (RUN):
  - in_ready = !full[wr_bank] && (blocks_loaded < BLOCK_NUM).
  - Beat counters advance on valid_B in writer order: col 0..N2-1 (fastest), then phase 0..BLOCK_WIDTHdN2-1, then row 0..M2-1.
  - Beats per block = N2*BLOCK_WIDTHdN2*M2.
  - On the final beat of a block: full[wr_bank]<=1, wr_bank toggles, blocks_loaded++, beat counters wrap to 0.
- Compute side (RUN): registered.
  - When !cbusy && full[rd_bank] && !compute_start: pulse compute_start for one cycle, set cbusy.
  - Earliest compute_start is the cycle after full is set.
  - compute_done with cbusy=1: full[rd_bank]<=0, rd_bank toggles, cbusy<=0, blocks_done++.
  - compute_done with cbusy=0: ignored.
- Completion:
  - The compute_done that makes blocks_done==BLOCK_NUM gives done=1 the next cycle.
  - Same cycle: state IDLE, busy=0, writer_rst=1.
- Simultaneous events:
  - A block-fill completion and a release in the same cycle always hit different halves (writes to a full half are blocked). Both take effect.
  - A freed half is writable the following cycle.
- start while in RUN: ignored.
- Width rules:
  - Compare counters against cfg-1 using MATRIXSIZE_W arithmetic.
  - blocks_loaded/blocks_done are MATRIXSIZE_W bits.
  - BLOCK_NUM up to 2^MATRIXSIZE_W-1 is supported.

Decomposition:
- Shared package: state enum type (IDLE, RUN) and a bank-index typedef (1 bit). Config struct {M2, BLOCK_WIDTHdN2, BLOCK_NUM} with MATRIXSIZE_W fields.
- Sub-module b_beat_counter: nested col/phase/row counter with inc input, cfg inputs, and last_beat output. Reusable for the matching A-side scheduler.

Test Plan:
1. Nominal run:
   - Stimulus: N2=4, M2=2, BLOCK_WIDTHdN2=1, BLOCK_NUM=3; in_valid held 1; compute_done 5 cycles after each compute_start.
   - Required: 24 valid_B beats total; wr_bank toggles after beats 8 and 16; compute_start pulses with rd_bank 0,1,0; single done pulse after the third compute_done.
2. Backpressure:
   - Stimulus: same config, compute_done withheld.
   - Required: after 16 beats both halves are full and in_ready=0 indefinitely. First compute_done re-asserts in_ready on the next cycle with wr_bank=0.
3. Config reject:
   - Stimulus: start with BLOCK_NUM=0.
   - Required: cfg_err pulses one cycle; busy stays 0; valid_B never asserts.
4. Reset mid-job:
   - Stimulus: rst asserted after 11 beats.
   - Required: next cycle all outputs equal their reset values. A new start restarts with wr_bank=0 and beat count 0.
5. Spurious and overlapping inputs:
   - Stimulus: compute_done while cbusy=0; start during RUN.
   - Required: no flag/bank change; job completes unchanged.
6. Upstream gaps:
   - Stimulus: in_valid toggling 1,0 each cycle.
   - Required: valid_B mirrors in_valid while in_ready=1; block boundaries still occur at exactly 8 accepted beats.
